// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

  // Controller states: IDLE waits for start, RUN does one quotient bit per
  // cycle, DONE presents the result for exactly one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/sub_n.sv
// Parameterised ripple-borrow subtractor: diff = x - y, borrow set when x < y.
module sub_n #(
  parameter int n = 5
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  output logic [n-1:0] diff,
  output logic         borrow
);

  logic [n:0] bw;

  assign bw[0] = 1'b0;

  // One full-subtractor cell per bit; the borrow ripples from LSB to MSB.
  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_bit
      assign diff[gi]   = x[gi] ^ y[gi] ^ bw[gi];
      assign bw[gi + 1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & bw[gi]);
    end
  endgenerate

  assign borrow = bw[n];

endmodule

// File: rtl/div_seq_n.sv
// Sequential restoring divider: one (m+1)-bit trial subtraction per cycle,
// dividend MSB first. All outputs come straight from registers.
module div_seq_n
  import div_pkg::*;
#(
  parameter int m = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [m-1:0] q,
  output logic [m-1:0] r,
  output logic         dbz
);

  localparam int            CW       = $clog2(m);
  localparam logic [CW-1:0] CNT_LOAD = CW'(m - 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Dividend shifts out of the top while quotient bits shift in at the bottom,
  // so after m steps this register holds the quotient.
  logic [m-1:0]  dvd_q, dvd_d;
  logic [m-1:0]  dvs_q, dvs_d;
  logic [m-1:0]  rem_q, rem_d;
  logic [m-1:0]  q_q, q_d;
  logic [m-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [m:0]    trial;
  logic [m:0]    diff;
  logic          borrow;
  logic [m-1:0]  rem_step;
  logic [m-1:0]  quo_step;
  logic          unused_diff_msb;

  // Partial remainder with the next dividend bit appended.
  assign trial = {rem_q, dvd_q[m-1]};

  sub_n #(
    .n(m + 1)
  ) u_sub (
    .x     (trial),
    .y     ({1'b0, dvs_q}),
    .diff  (diff),
    .borrow(borrow)
  );

  // On borrow the trial value is restored; either way the kept value is < b,
  // so its top bit is always zero and can be dropped.
  assign rem_step        = borrow ? trial[m-1:0] : diff[m-1:0];
  assign quo_step        = {dvd_q[m-2:0], ~borrow};
  assign unused_diff_msb = diff[m];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      dbz_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dbz_q  <= dbz_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Next-state logic and next values for the datapath; results only move
  // into q/r/dbz on entry to DONE so they stay stable between divisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (b != '0) begin
            dvd_d   = a;
            dvs_d   = b;
            rem_d   = '0;
            cnt_d   = CNT_LOAD;
            state_d = RUN;
          end else begin
            q_d     = '1;
            r_d     = a;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        if (cnt_q == '0) begin
          q_d     = quo_step;
          r_d     = rem_step;
          dbz_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: doc/div_seq_n.md
DIV_SEQ_N -- requirements
Module: div_seq_n

Interface
REQ-001 SHALL have parameter m, default 4: operand, quotient and remainder width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port a  input  m  unsigned dividend; captured on the accepting edge.
REQ-006 SHALL have port b  input  m  unsigned divisor; captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while a division is in progress (RUN).
REQ-008 SHALL have port done  output  1  single-cycle pulse; q, r and dbz are valid when it is high.
REQ-009 SHALL have port q  output  m  quotient.
REQ-010 SHALL have port r  output  m  remainder.
REQ-011 SHALL have port dbz  output  1  divide-by-zero flag for the last result.

Function
REQ-012 SHALL implement a restoring divider that is the inverse of the team's n-bit ripple adder: one (m+1)-bit trial subtraction per cycle, MSB of the dividend first.
REQ-013 SHALL use the three-state FSM IDLE, RUN and DONE; the reset state is IDLE.
REQ-014 SHALL, in IDLE with start=1 and b!=0, capture a and b, clear the partial remainder, load the step counter with m-1, and go to RUN.
REQ-015 SHALL, in IDLE with start=1 and b=0, go directly to DONE with q=all ones, r=a and dbz=1.
REQ-016 SHALL, on each RUN edge, shift the next dividend bit into the partial remainder, subtract b, keep the difference and shift in quotient bit 1 if there is no borrow, and otherwise restore and shift in 0.
REQ-017 SHALL go from RUN to DONE on the edge where the counter equals 0; otherwise it SHALL decrement the counter.
REQ-018 SHALL raise done exactly m+1 rising edges after the edge that accepted start (b!=0), or 1 edge after it (b=0).
REQ-019 SHALL always return from DONE to IDLE on the next edge, so done lasts exactly one cycle.
REQ-020 SHALL ignore start while in RUN or DONE, without queuing it.
REQ-021 SHALL ensure that a change on a or b after acceptance has no effect on the result.
REQ-022 SHALL hold q, r and dbz stable from done until the next accepting edge.
REQ-023 SHALL allow start to be asserted in the cycle where done=1 (state DONE), in which case it is ignored; the earliest accepted start is the cycle after done.
REQ-024 SHALL satisfy a == q*b + r with r < b for every b!=0.
REQ-025 SHALL hold busy=1 exactly while in RUN.
REQ-026 SHALL drive every output from a register, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, on rst=1 and regardless of clk, force state=IDLE, busy=0, done=0, q=0, r=0, dbz=0 and counter=0.
REQ-028 SHALL abort any division that is in progress when rst is asserted, with no done pulse.
REQ-029 SHALL accept start on the first rising edge after rst is deasserted.

Structure
REQ-030 SHALL take the state enum type (IDLE/RUN/DONE) from the shared package div_pkg.
REQ-031 SHALL instantiate exactly one sub-module, sub_n: a parameterised (m+1)-bit ripple subtractor with outputs difference and borrow.
REQ-032 SHALL size the counter as $clog2(m) bits.

Verification
REQ-033 SHALL verify, with m=4: a=13, b=3, start pulse -> busy for 4 cycles, then done pulse with q=4, r=1, dbz=0.
REQ-034 SHALL verify, with m=4: a=2, b=5 -> q=0, r=2, dbz=0, with done 5 edges after acceptance.
REQ-035 SHALL verify, with m=4: a=7, b=0 -> done on the next edge, q=15, r=7, dbz=1, and busy never high.
REQ-036 SHALL verify, with m=4: a=15, b=1, then start held high continuously -> q=15, r=0; the second division is accepted only the cycle after done and gives the same result.
REQ-037 SHALL verify, with m=4: rst pulsed during the second RUN cycle of 9/2 -> all outputs 0, no done; a following 9/2 gives q=4, r=1.
REQ-038 SHALL verify, with m=8: an exhaustive sweep of a and b (b!=0) compared against a reference model, checking REQ-024 and the latency for every pair.
